// File: rtl/bcd_scan_display.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : bcd_scan_display                                                 |
// | Brief   : Sequential binary-to-BCD converter feeding a time-multiplexed    |
// |           digit scanner with leading-zero blanking and per-field blink.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module bcd_scan_display #(
    parameter  int FIELDS     = 4,
    parameter  int FIELD_BITS = 8,
    parameter  int FDIG       = 2,
    parameter  int SCAN_DIV   = 100000,
    parameter  int BLINK_DIV  = 25000000,
    localparam int DIGITS     = FIELDS * FDIG,
    localparam int AN_W       = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [FIELDS*FIELD_BITS-1:0] fields,
    input  logic                         update,
    input  logic                         lz_blank,
    input  logic [FIELDS-1:0]            blink_sel,
    output logic [3:0]                   data,
    output logic [AN_W-1:0]              an,
    output logic                         blank,
    output logic                         busy,
    output logic [FIELDS-1:0]            ovf
);

    localparam int c_ACC_W = FDIG * 4;
    localparam int c_FLD_W = (FIELDS > 1) ? $clog2(FIELDS) : 1;
    localparam int c_BIT_W = (FIELD_BITS > 1) ? $clog2(FIELD_BITS) : 1;
    localparam int c_PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int c_BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [c_FLD_W-1:0] c_FLD_LAST = c_FLD_W'(FIELDS - 1);
    localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(FIELD_BITS - 1);
    localparam logic [c_PRE_W-1:0] c_PRE_LAST = c_PRE_W'(SCAN_DIV - 1);
    localparam logic [c_BLK_W-1:0] c_BLK_LAST = c_BLK_W'(BLINK_DIV - 1);
    localparam logic [AN_W-1:0]    c_AN_LAST  = AN_W'(DIGITS - 1);
    localparam logic [63:0]        c_MAX_VAL  = 64'(10 ** FDIG - 1);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_CONV = 1'b1;

    logic [0:0]                   r_state;
    logic [0:0]                   w_state_next;
    logic                         w_start;
    logic                         w_done;
    logic                         r_pend;
    logic [FIELDS*FIELD_BITS-1:0] r_shadow;
    logic [c_FLD_W-1:0]           r_fld;
    logic [c_BIT_W-1:0]           r_bit;
    logic [c_ACC_W-1:0]           r_acc;
    logic [c_ACC_W-1:0]           w_corr;
    logic [c_ACC_W-1:0]           w_acc_next;
    logic                         w_bit_in;
    logic [DIGITS*4-1:0]          r_stage;
    logic [DIGITS*4-1:0]          w_final;
    logic [DIGITS*4-1:0]          r_disp;
    logic [FIELDS-1:0]            w_ovf;
    logic [FIELDS-1:0]            r_ovf;
    logic [c_PRE_W-1:0]           r_pre;
    logic [AN_W-1:0]              r_an;
    logic [c_BLK_W-1:0]           r_blk;
    logic                         r_phase;
    logic [DIGITS-1:0]            w_slot_blank;

    assign w_done = (r_state == c_CONV) && (r_fld == c_FLD_LAST) && (r_bit == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= c_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (update) begin
                    w_state_next = c_CONV;
                    w_start      = 1'b1;
                end
            end
            c_CONV: begin
                if (w_done) begin
                    if (r_pend || update) w_start      = 1'b1;
                    else                  w_state_next = c_IDLE;
                end
            end
            default: w_state_next = c_IDLE;
        endcase
    end

    // One double-dabble step: add-3 on every digit >= 5, then shift in the next bit MSB-first.
    assign w_bit_in = r_shadow[int'(r_fld) * FIELD_BITS + int'(r_bit)];

    for (genvar g = 0; g < FDIG; g++) begin : g_dig
        assign w_corr[g*4 +: 4] = (r_acc[g*4 +: 4] >= 4'd5) ? r_acc[g*4 +: 4] + 4'd3
                                                            : r_acc[g*4 +: 4];
    end

    assign w_acc_next = {w_corr[c_ACC_W-2:0], w_bit_in};

    always_comb begin
        w_final = r_stage;
        w_final[(FIELDS-1)*c_ACC_W +: c_ACC_W] = w_acc_next;
    end

    for (genvar i = 0; i < FIELDS; i++) begin : g_ovf
        assign w_ovf[i] = 64'(r_shadow[i*FIELD_BITS +: FIELD_BITS]) > c_MAX_VAL;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shadow <= '0;
            r_acc    <= '0;
            r_stage  <= '0;
            r_fld    <= '0;
            r_bit    <= c_BIT_LAST;
            r_pend   <= 1'b0;
            r_disp   <= '0;
            r_ovf    <= '0;
        end else begin
            if (r_state == c_CONV) begin
                if (r_bit == '0) begin
                    r_stage[int'(r_fld)*c_ACC_W +: c_ACC_W] <= w_acc_next;
                    r_acc <= '0;
                    r_bit <= c_BIT_LAST;
                    r_fld <= r_fld + 1'b1;
                end else begin
                    r_acc <= w_acc_next;
                    r_bit <= r_bit - 1'b1;
                end
            end
            // Display and overflow flags only ever change together, on the final step.
            if (w_done) begin
                r_disp <= w_final;
                r_ovf  <= w_ovf;
                r_fld  <= '0;
            end
            if (w_start) begin
                r_shadow <= fields;
                r_acc    <= '0;
                r_fld    <= '0;
                r_bit    <= c_BIT_LAST;
            end
            if (w_done)                              r_pend <= 1'b0;
            else if ((r_state == c_CONV) && update)  r_pend <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pre <= '0;
            r_an  <= '0;
        end else if (r_pre == c_PRE_LAST) begin
            r_pre <= '0;
            r_an  <= (r_an == c_AN_LAST) ? '0 : r_an + 1'b1;
        end else begin
            r_pre <= r_pre + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_blk   <= '0;
            r_phase <= 1'b0;
        end else if (r_blk == c_BLK_LAST) begin
            r_blk   <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_blk <= r_blk + 1'b1;
        end
    end

    // A slot is LZ-blank when it and every higher digit of its field are zero.
    for (genvar k = 0; k < DIGITS; k++) begin : g_slot
        localparam int c_FLD = k / FDIG;
        localparam int c_DIG = k % FDIG;
        logic w_hi_zero;
        assign w_hi_zero       = (r_disp[k*4 +: (FDIG-c_DIG)*4] == '0);
        assign w_slot_blank[k] = (lz_blank && (c_DIG != 0) && w_hi_zero) ||
                                 (r_phase && blink_sel[c_FLD]);
    end

    assign an    = r_an;
    assign busy  = (r_state == c_CONV);
    assign ovf   = r_ovf;
    assign blank = w_slot_blank[r_an];
    assign data  = blank ? 4'd0 : r_disp[int'(r_an)*4 +: 4];

endmodule
`default_nettype wire

// File: tb/tb_bcd_scan_display.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_bcd_scan_display                                              |
// | Brief   : Self-checking bench with an arithmetic reference display model.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_bcd_scan_display;

    localparam int FIELDS     = 4;
    localparam int FIELD_BITS = 8;
    localparam int FDIG       = 2;
    localparam int SCAN_DIV   = 4;
    localparam int BLINK_DIV  = 16;
    localparam int DIGITS     = FIELDS * FDIG;
    localparam int AN_W       = 3;

    logic                         clk = 1'b0;
    logic                         reset;
    logic [FIELDS*FIELD_BITS-1:0] fields;
    logic                         update;
    logic                         lz_blank;
    logic [FIELDS-1:0]            blink_sel;
    logic [3:0]                   data;
    logic [AN_W-1:0]              an;
    logic                         blank;
    logic                         busy;
    logic [FIELDS-1:0]            ovf;

    int checks = 0;
    int errors = 0;
    int cyc;
    int cur  [FIELDS];
    int vals [FIELDS];

    bcd_scan_display #(
        .FIELDS(FIELDS), .FIELD_BITS(FIELD_BITS), .FDIG(FDIG),
        .SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV)
    ) dut (
        .clk(clk), .reset(reset), .fields(fields), .update(update),
        .lz_blank(lz_blank), .blink_sel(blink_sel), .data(data), .an(an),
        .blank(blank), .busy(busy), .ovf(ovf)
    );

    always #5 clk = ~clk;

    // Clocks since reset release; scan slot and blink phase follow from it.
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int p10(input int d);
        int r = 1;
        for (int j = 0; j < d; j++) r = r * 10;
        return r;
    endfunction

    function automatic logic [FIELDS-1:0] exp_ovf();
        logic [FIELDS-1:0] e;
        for (int i = 0; i < FIELDS; i++) e[i] = (vals[i] > p10(FDIG) - 1);
        return e;
    endfunction

    task automatic drive_fields();
        for (int i = 0; i < FIELDS; i++) fields[i*FIELD_BITS +: FIELD_BITS] = FIELD_BITS'(cur[i]);
    endtask

    task automatic rand_fields();
        for (int i = 0; i < FIELDS; i++)
            cur[i] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 9)) : int'($urandom_range(0, 255));
        drive_fields();
    endtask

    task automatic convert();
        int n;
        @(negedge clk);
        drive_fields();
        update = 1'b1;
        @(negedge clk);
        update = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("busy_len", n, 32);
        for (int i = 0; i < FIELDS; i++) vals[i] = cur[i];
        chk("ovf", ovf, exp_ovf());
    endtask

    task automatic check_display(input int ncyc, input bit rnd);
        int k, f, d, dig, tail;
        bit eb;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            if (rnd) begin
                lz_blank  = 1'($urandom);
                blink_sel = FIELDS'($urandom);
            end
            #1;
            k    = (cyc / SCAN_DIV) % DIGITS;
            f    = k / FDIG;
            d    = k % FDIG;
            dig  = (vals[f] / p10(d)) % 10;
            tail = (vals[f] % p10(FDIG)) / p10(d);
            eb   = (lz_blank && d != 0 && tail == 0) ||
                   (((cyc / BLINK_DIV) % 2 == 1) && blink_sel[f]);
            chk("an", an, k);
            chk("blank", blank, eb);
            chk("data", data, eb ? 0 : dig);
            chk("busy_idle", busy, 0);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        reset     = 1'b1;
        update    = 1'b0;
        fields    = '0;
        lz_blank  = 1'b0;
        blink_sel = '0;
        for (int i = 0; i < FIELDS; i++) begin cur[i] = 0; vals[i] = 0; end

        repeat (3) @(negedge clk);
        #1;
        chk("rst_an", an, 0);
        chk("rst_data", data, 0);
        chk("rst_blank", blank, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", ovf, 0);
        @(negedge clk);
        reset = 1'b0;

        // Mixed field values, free-running scan over more than one full frame.
        cur[0] = 23; cur[1] = 59; cur[2] = 7; cur[3] = 255;
        convert();
        chk("ovf_scn1", ovf, 4'b1000);
        check_display(40, 1'b0);

        // Leading-zero blanking: single-digit field and an all-zero field.
        cur[0] = 0; cur[1] = 7;
        convert();
        lz_blank = 1'b1;
        check_display(40, 1'b0);

        // Blink on field 1 only, across both phases.
        lz_blank  = 1'b0;
        blink_sel = 4'b0010;
        check_display(48, 1'b0);
        blink_sel = '0;

        // Overflow boundary around 99/100.
        cur[0] = 9; cur[1] = 10; cur[2] = 99; cur[3] = 100;
        convert();
        chk("ovf_boundary", ovf, 4'b1000);
        check_display(36, 1'b1);

        // Three merged requests during conversion -> exactly one extra conversion.
        rand_fields();
        @(negedge clk);
        update = 1'b1;
        @(negedge clk);
        update = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 300) begin
            n++;
            if (n == 5 || n == 10 || n == 15 || n == 20) begin
                rand_fields();
                update = (n != 20);
            end else begin
                update = 1'b0;
            end
            @(negedge clk);
        end
        update = 1'b0;
        chk("busy_merged", n, 64);
        for (int i = 0; i < FIELDS; i++) vals[i] = cur[i];
        chk("ovf_merged", ovf, exp_ovf());
        check_display(24, 1'b1);

        // Reset in the middle of a conversion.
        lz_blank  = 1'b0;
        blink_sel = '0;
        rand_fields();
        @(negedge clk);
        update = 1'b1;
        @(negedge clk);
        update = 1'b0;
        repeat (9) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_ovf", ovf, 0);
        chk("abort_an", an, 0);
        chk("abort_data", data, 0);
        chk("abort_blank", blank, 0);
        for (int i = 0; i < FIELDS; i++) vals[i] = 0;
        @(negedge clk);
        reset = 1'b0;
        check_display(34, 1'b0);
        convert();
        check_display(34, 1'b1);

        // Randomized conversions with randomized blanking controls.
        repeat (6) begin
            rand_fields();
            convert();
            check_display(36, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bcd_scan_display.md
BCD_SCAN_DISPLAY -- requirements
Module: bcd_scan_display

Interface
REQ-001 Parameters SHALL be FIELDS (4), number of binary fields; FIELD_BITS (8), bits per field; FDIG (2), BCD digits shown per field; SCAN_DIV (100000), clocks per digit slot; BLINK_DIV (25000000), clocks per blink half-period.
REQ-002 Derived constants SHALL be DIGITS = FIELDS*FDIG and AN_W = clog2(DIGITS), minimum 1.
REQ-003 The module SHALL have input clk, 1 bit: the only clock.
REQ-004 The module SHALL have input reset, 1 bit: asynchronous, active-high.
REQ-005 The module SHALL have input fields, FIELDS*FIELD_BITS bits: packed binary values, field 0 in the LSBs.
REQ-006 The module SHALL have input update, 1 bit: conversion request, sampled on each clk edge.
REQ-007 The module SHALL have input lz_blank, 1 bit: enable per-field leading-zero blanking.
REQ-008 The module SHALL have input blink_sel, FIELDS bits: per-field blink enable.
REQ-009 The module SHALL have output data, 4 bits: BCD digit for the current slot.
REQ-010 The module SHALL have output an, AN_W bits: current digit slot index.
REQ-011 The module SHALL have output blank, 1 bit: current slot dark.
REQ-012 The module SHALL have output busy, 1 bit: conversion in progress.
REQ-013 The module SHALL have output ovf, FIELDS bits: per-field value exceeds 10^FDIG-1.

Function
REQ-014 The conversion FSM SHALL have states IDLE and CONV; it SHALL go IDLE->CONV on any edge where update=1 in IDLE, latching fields into a shadow register on that edge.
REQ-015 CONV SHALL run sequential double-dabble, one shift (with add-3 correction) per clock, fields converted in order 0..FIELDS-1, for exactly FIELDS*FIELD_BITS cycles with busy=1 throughout.
REQ-016 Each field SHALL use an FDIG-digit BCD accumulator; bits carried out of the top digit SHALL be discarded, so digits equal value mod 10^FDIG.
REQ-017 ovf[i] SHALL be 1 iff field i's latched value exceeds 10^FDIG-1.
REQ-018 On the final CONV edge, all DIGITS display digits and all ovf bits SHALL update atomically; no partial result SHALL ever reach data or ovf.
REQ-019 An update=1 seen during CONV SHALL set one pending flag; further requests before completion SHALL merge into it.
REQ-020 At completion with pending set, the FSM SHALL stay in CONV, re-latch fields on the completion edge, clear pending, and keep busy high; otherwise it SHALL return to IDLE with busy=0 on the following cycle.
REQ-021 The scan prescaler SHALL count 0..SCAN_DIV-1; on terminal count an SHALL advance, wrapping DIGITS-1 -> 0, so each slot lasts exactly SCAN_DIV clocks.
REQ-022 Slot k SHALL show field k/FDIG, digit k mod FDIG, with digit 0 the least significant.
REQ-023 data SHALL be the stored digit for slot an, forced to 0 whenever blank=1; data and blank SHALL be combinational from registered state.
REQ-024 With lz_blank=1, a slot SHALL be blanked if its digit and all higher digits of the same field are 0; digit 0 of a field SHALL never be LZ-blanked.
REQ-025 A blink phase bit SHALL toggle every BLINK_DIV clocks; while phase=1, all slots of fields with blink_sel[i]=1 SHALL be blank.
REQ-026 blink_sel and lz_blank SHALL act immediately, with no latching.

Reset
REQ-027 While reset=1, outputs SHALL be an=0, data=0, blank=0, busy=0, ovf=0.
REQ-028 Reset SHALL clear FSM (to IDLE), pending, prescaler, blink phase and display digits.
REQ-029 Reset asserted mid-conversion SHALL abort the conversion with no display update.
REQ-030 The first update after reset release SHALL be honoured normally.

Verification (bench overrides SCAN_DIV=4, BLINK_DIV=16; other parameters default)
REQ-031 Scenario: fields={255,7,59,23} (field3..0) plus a 1-cycle update -> busy high 32 cycles; field0 slots show 3,2, field1 9,5, field2 7,0, field3 5,5; ovf=4'b1000.
REQ-032 Scenario: free-running scan -> an sequence 0..7,0 with each value held exactly 4 clocks.
REQ-033 Scenario: lz_blank=1 with field1=7 -> slot 3 blank with data 0, slot 2 shows 7; field0=0 -> slot 0 shows 0 unblanked, slot 1 blank.
REQ-034 Scenario: blink_sel=4'b0010 -> slots 2-3 blank for 16 clocks then visible for 16 clocks, repeating; other slots never blink-blanked.
REQ-035 Scenario: update pulsed 3 times during CONV with fields changed -> exactly one extra conversion using fields present at the completion edge; busy continuous for 64 cycles.
REQ-036 Scenario: reset asserted at CONV cycle 10 -> busy=0, digits=0, ovf=0 at once; a fresh update then converts correctly.
